// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers: radix-2 shift-add multiply and restoring divide.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (ops 6-9) accumulating into {hi,lo}.
module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       mdu_op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       op_reg, op_next;
   logic [W2-1:0]    work_reg, work_next;
   logic [WIDTH-1:0] opb_reg, opb_next;
   logic [WIDTH-1:0] rs_reg, rs_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             neg_a_reg, neg_a_next;
   logic             neg_b_reg, neg_b_next;
   logic             rt_zero_reg, rt_zero_next;
   logic             done_reg, done_next;
   logic             dz_reg, dz_next;

   // Decode of the incoming request
   logic in_iter, in_signed;
   always_comb begin
      in_iter   = 1'b0;
      in_signed = 1'b0;
      case (mdu_op)
         4'd0, 4'd2: begin in_iter = 1'b1; in_signed = 1'b1; end
         4'd1, 4'd3: in_iter = 1'b1;
`ifdef MDU_MADD_EN
         4'd6, 4'd8: begin in_iter = 1'b1; in_signed = 1'b1; end
         4'd7, 4'd9: in_iter = 1'b1;
`endif
         default: ;
      endcase
   end

   logic             in_neg_a, in_neg_b;
   logic [WIDTH-1:0] mag_rs, mag_rt;
   assign in_neg_a = in_signed & rs[WIDTH-1];
   assign in_neg_b = in_signed & rt[WIDTH-1];
   assign mag_rs   = in_neg_a ? -rs : rs;
   assign mag_rt   = in_neg_b ? -rt : rt;

   // One iteration of each algorithm; work_reg holds {partial, multiplier} or {remainder, quotient}
   logic [WIDTH:0]  mul_sum, div_shift, div_diff;
   logic [W2-1:0]   mul_step, div_step;
   always_comb begin
      mul_sum   = {1'b0, work_reg[W2-1:WIDTH]} + {1'b0, (work_reg[0] ? opb_reg : {WIDTH{1'b0}})};
      mul_step  = {mul_sum, work_reg[WIDTH-1:1]};
      div_shift = work_reg[W2-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opb_reg};
      div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  work_reg[WIDTH-2:0], 1'b1};
   end

   // Sign correction of the magnitude results
   logic             is_div, res_neg;
   logic [W2-1:0]    prod_fix, mul_result;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   assign is_div   = (op_reg == 4'd2) || (op_reg == 4'd3);
   assign res_neg  = neg_a_reg ^ neg_b_reg;
   assign prod_fix = res_neg ? -work_reg : work_reg;
   assign quo_fix  = res_neg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
   assign rem_fix  = neg_a_reg ? -work_reg[W2-1:WIDTH] : work_reg[W2-1:WIDTH];

`ifdef MDU_MADD_EN
   logic is_acc, is_sub;
   assign is_acc = (op_reg >= 4'd6) && (op_reg <= 4'd9);
   assign is_sub = (op_reg == 4'd8) || (op_reg == 4'd9);
   always_comb begin
      if (!is_acc)
         mul_result = prod_fix;
      else if (is_sub)
         mul_result = {hi_reg, lo_reg} - prod_fix;
      else
         mul_result = {hi_reg, lo_reg} + prod_fix;
   end
`else
   assign mul_result = prod_fix;
`endif

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      op_next      = op_reg;
      work_next    = work_reg;
      opb_next     = opb_reg;
      rs_next      = rs_reg;
      hi_next      = hi_reg;
      lo_next      = lo_reg;
      neg_a_next   = neg_a_reg;
      neg_b_next   = neg_b_reg;
      rt_zero_next = rt_zero_reg;
      done_next    = 1'b0;
      dz_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (in_iter) begin
                  state_next   = CALC;
                  cnt_next     = '0;
                  op_next      = mdu_op;
                  work_next    = {{WIDTH{1'b0}}, mag_rs};
                  opb_next     = mag_rt;
                  rs_next      = rs;
                  neg_a_next   = in_neg_a;
                  neg_b_next   = in_neg_b;
                  rt_zero_next = (rt == '0);
               end else if (mdu_op == 4'd4) begin
                  hi_next = rs;
               end else if (mdu_op == 4'd5) begin
                  lo_next = rs;
               end
            end
         end
         CALC: begin
            work_next = is_div ? div_step : mul_step;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH - 1))
               state_next = FIX;
         end
         FIX: begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
            if (is_div) begin
               // Divide by zero returns all-ones quotient and the untouched dividend
               if (rt_zero_reg) begin
                  hi_next = rs_reg;
                  lo_next = {WIDTH{1'b1}};
                  dz_next = 1'b1;
               end else begin
                  hi_next = rem_fix;
                  lo_next = quo_fix;
               end
            end else begin
               {hi_next, lo_next} = mul_result;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= '0;
         op_reg      <= '0;
         work_reg    <= '0;
         opb_reg     <= '0;
         rs_reg      <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         neg_a_reg   <= 1'b0;
         neg_b_reg   <= 1'b0;
         rt_zero_reg <= 1'b0;
         done_reg    <= 1'b0;
         dz_reg      <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         op_reg      <= op_next;
         work_reg    <= work_next;
         opb_reg     <= opb_next;
         rs_reg      <= rs_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
         neg_a_reg   <= neg_a_next;
         neg_b_reg   <= neg_b_next;
         rt_zero_reg <= rt_zero_next;
         done_reg    <= done_next;
         dz_reg      <= dz_next;
      end
   end

   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;
   assign div_zero = dz_reg;
   assign hi       = hi_reg;
   assign lo       = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, hand-written corner sequences and a randomized
// run against an arithmetic reference model.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [3:0]  mdu_op;
   logic [31:0] rs, rt;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op), .rs(rs), .rt(rt),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, e_hi, e_lo;
      logic        e_dz;
   } vec_t;

   vec_t vecs[12];

   logic [31:0] m_hi, m_lo;
   logic        m_dz;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference model from the arithmetic definitions
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      m_dz = 1'b0;
      p = ((op == 4'd0) || (op == 4'd6) || (op == 4'd8)) ? sa * sb : ua * ub;
      case (op)
         4'd0, 4'd1: {m_hi, m_lo} = p;
         4'd6, 4'd7: {m_hi, m_lo} = {m_hi, m_lo} + p;
         4'd8, 4'd9: {m_hi, m_lo} = {m_hi, m_lo} - p;
         4'd2, 4'd3: begin
            if (b == 32'd0) begin
               m_dz = 1'b1;
               m_lo = 32'hFFFF_FFFF;
               m_hi = a;
            end else begin
               if (op == 4'd2) begin q = sa / sb; r = sa % sb; end
               else begin q = ua / ub; r = ua % ub; end
               m_lo = q[31:0];
               m_hi = r[31:0];
            end
         end
         4'd4: m_hi = a;
         4'd5: m_lo = a;
         default: ;
      endcase
   endtask

   // Pulse start for one edge; afterwards scramble operands to show they are not used
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      mdu_op = op; rs = a; rt = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rs = $urandom; rt = $urandom;
   endtask

   // Wait (bounded) for done; checks latency, busy span and optionally the one-cycle pulse
   task automatic wait_done(input string tag, input int exp_cyc, input bit chk_pulse,
                            output logic [31:0] g_hi, output logic [31:0] g_lo, output logic g_dz);
      int cyc, nb;
      cyc = 0;
      nb = busy ? 1 : 0;
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (busy && !done) nb++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
      check({tag, "_busy_span"}, 64'(nb), 64'(exp_cyc));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      g_hi = hi; g_lo = lo; g_dz = div_zero;
      $display("%s: op=%0d hi=%h lo=%h div_zero=%b cycles=%0d", tag, mdu_op, hi, lo, div_zero, cyc);
      if (chk_pulse) begin
         @(posedge clk); #1;
         check({tag, "_pulse_end"}, {62'd0, done, div_zero}, 64'd0);
      end
   endtask

   task automatic do_move(input logic [3:0] op, input logic [31:0] v);
      issue(op, v, 32'h0);
      check($sformatf("move%0d_flags", op), {61'd0, busy, done, div_zero}, 64'd0);
      check($sformatf("move%0d_value", op), 64'(op == 4'd4 ? hi : lo), 64'(v));
      $display("move op=%0d value=%h hi=%h lo=%h", op, v, hi, lo);
   endtask

   initial begin
      logic [31:0] g_hi, g_lo;
      logic        g_dz;
      int          n_done;
      logic [3:0]  ops[$];

      vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{4'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{4'd3, 32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF, 1'b1};
      vecs[4]  = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
      vecs[5]  = '{4'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 1'b0};
      vecs[6]  = '{4'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3,         1'b0};
      vecs[7]  = '{4'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0,         32'hF,         1'b0};
      vecs[8]  = '{4'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0};
      vecs[9]  = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1'b0};
      vecs[10] = '{4'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[11] = '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0};

      rst = 1'b1; start = 1'b0; mdu_op = 4'd0; rs = '0; rt = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i), 33, 1'b1, g_hi, g_lo, g_dz);
         check($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(vecs[i].e_hi));
         check($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(vecs[i].e_lo));
         check($sformatf("vec%0d_dz", i), 64'(g_dz), 64'(vecs[i].e_dz));
      end

      // mthi in idle, then divide with a start and an mthi issued while busy
      do_move(4'd4, 32'h1234);
      issue(4'd3, 32'd100, 32'd7);
      repeat (5) begin @(posedge clk); #1; end
      mdu_op = 4'd0; rs = 32'd9; rt = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      mdu_op = 4'd4; rs = 32'hDEAD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_mthi_ignored", 64'(hi), 64'h1234);
      wait_done("busy_ignore", 26, 1'b1, g_hi, g_lo, g_dz);
      check("busy_ignore_hi", 64'(g_hi), 64'd2);
      check("busy_ignore_lo", 64'(g_lo), 64'd14);

      // Reset in the middle of a divide
      issue(4'd2, 32'hFFFF_FFF9, 32'd2);
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_flags", {61'd0, busy, done, div_zero}, 64'd0);
      n_done = 0;
      repeat (40) begin @(posedge clk); #1; if (done || busy) n_done++; end
      check("midrst_no_done", 64'(n_done), 64'd0);
      $display("mid-divide reset: hi=%h lo=%h", hi, lo);

      // Undefined ops are ignored
      do_move(4'd4, 32'h55);
      do_move(4'd5, 32'hAA);
      issue(4'd12, 32'h1111, 32'h2222);
      check("undef12_busy", 64'(busy), 64'd0);
`ifndef MDU_MADD_EN
      issue(4'd6, 32'h3, 32'h4);
      check("undef6_busy", 64'(busy), 64'd0);
`endif
      repeat (3) begin @(posedge clk); #1; end
      check("undef_hilo", {hi, lo}, {32'h55, 32'hAA});
      check("undef_done", 64'(done), 64'd0);

      // Back-to-back: new start in the done cycle
      issue(4'd1, 32'd6, 32'd7);
      wait_done("b2b_first", 33, 1'b0, g_hi, g_lo, g_dz);
      check("b2b_first_lo", 64'(g_lo), 64'd42);
      issue(4'd0, 32'hFFFF_FFFE, 32'd3);
      wait_done("b2b_second", 33, 1'b1, g_hi, g_lo, g_dz);
      check("b2b_second_hilo", {g_hi, g_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

`ifdef MDU_MADD_EN
      do_move(4'd5, 32'd5);
      do_move(4'd4, 32'd0);
      issue(4'd6, 32'd3, 32'd4);
      wait_done("madd", 33, 1'b1, g_hi, g_lo, g_dz);
      check("madd_hilo", {g_hi, g_lo}, 64'd17);
      issue(4'd8, 32'd2, 32'd10);
      wait_done("msub", 33, 1'b1, g_hi, g_lo, g_dz);
      check("msub_hilo", {g_hi, g_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9};
`else
      ops = '{4'd0, 4'd1, 4'd2, 4'd3};
`endif

      // Randomized run against the reference model
      do_move(4'd4, 32'h0);
      do_move(4'd5, 32'h0);
      m_hi = 32'h0; m_lo = 32'h0;
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = ops[$urandom_range(0, ops.size() - 1)];
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = b >> $urandom_range(16, 31);
            default: ;
         endcase
         model(op, a, b);
         issue(op, a, b);
         wait_done($sformatf("rand%0d", i), 33, 1'b1, g_hi, g_lo, g_dz);
         check($sformatf("rand%0d_hilo", i), {g_hi, g_lo}, {m_hi, m_lo});
         check($sformatf("rand%0d_dz", i), 64'(g_dz), 64'(m_dz));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the MIPS execute stage; sits beside the combinational ALU and owns the architectural HI/LO registers.
- Implements mult/multu/div/divu/mthi/mtlo with a start/busy/done handshake.
- Adds sequential behaviour the ALU lacks: multi-cycle radix-2 shift-add multiplication, restoring division, a divide-by-zero flag and, optionally, multiply-accumulate.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be even and at least 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- mdu_op  input  4  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu.
- rs  input  WIDTH  operand A / dividend / move source.
- rt  input  WIDTH  operand B / divisor.
- busy  output  1  an iterative operation is in progress.
- done  output  1  one-cycle pulse; hi and lo hold the new result.
- div_zero  output  1  one-cycle pulse with done when a div/divu had rt=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: on a rising clk edge with rst=1, the following go to 0: hi, lo, busy, done, div_zero, the counter and the FSM (IDLE).
  - rst overrides start and aborts any operation in progress; no done pulse is produced.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC: start=1 and op in {0,1,2,3,6,7,8,9}. Latch operands and op; clear the counter.
  - CALC -> FIX: after exactly WIDTH iterations, one bit per cycle.
  - FIX -> IDLE: apply sign correction/accumulate; write hi/lo.
- Latency:
  - Start sampled at edge E0.
  - busy=1 after E0 until edge E0+WIDTH+1.
  - hi/lo are updated at edge E0+WIDTH+1.
  - done=1 for the single cycle after that edge, with busy=0 in the same cycle.
  - Total: WIDTH+1 clocks from start to done.
- Back-to-back: a new start asserted during the done cycle is accepted, because busy=0.
- start while busy=1: ignored; operands and op are not relatched.
- mthi/mtlo (op 4/5) while IDLE:
  - Write rs to hi or lo at the sampling edge; no busy, no done.
  - While busy: ignored.
- Undefined op (10–15): ignored; no state change.
- mult/multu:
  - {hi,lo} = 2*WIDTH-bit product.
  - Signed ops take magnitudes in CALC; FIX negates the product if the operand signs differ.
- div/divu:
  - lo = quotient, hi = remainder, truncating toward zero.
  - Signed: quotient negated if the operand signs differ; remainder takes the sign of rs.
  - Signed MIN / -1: lo = MIN (0x80000000 at WIDTH=32), hi = 0; no flag.
- Divide by zero (rt=0 on op 2/3):
  - Still takes the full latency.
  - Result: lo = all ones, hi = rs unchanged.
  - div_zero pulses together with done.
- Operands rs and rt may change after the start edge without affecting the result.
- hi/lo hold their values between operations and during CALC; they change only at the FIX edge, on mthi/mtlo, or on reset.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 6–9 take the same path as mult/multu. FIX computes {hi,lo} = {hi,lo} ± product, modulo 2^(2*WIDTH); madd/msub use the signed product, maddu/msubu the unsigned product. The old {hi,lo} value is the value present at the FIX edge.
- Undefined: ops 6–9 are treated as undefined (ignored); no accumulate logic is synthesised.

Test Plan (WIDTH=32):
- Reset, then mult rs=0xFFFFFFFF, rt=0x00000002 -> done exactly 33 clocks after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for 33 cycles.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu rs=100, rt=0 -> done after 33 clocks; div_zero=1 for that cycle only; lo=0xFFFFFFFF, hi=100.
- div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start issued while busy and ignored; mthi 0x1234 issued in idle; rst asserted mid-divide -> the ignored start has no effect, hi=0x1234 after the mthi, and everything is 0 with no done after rst.
- With MDU_MADD_EN: mtlo 5, mthi 0, then madd 3*4 -> {hi,lo}=17; then msub 2*10 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
